scan_decoder_nbit: RTL and testbench
====================================

SCAN_DECODER_NBIT -- requirements
Module: scan_decoder_nbit

Interface
REQ-001 Parameter N, default 3, is the select width; the legal range is 1..6.
REQ-002 Parameter DWELL_W, default 4, is the dwell-counter width.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port enable, input, 1 bit: 1 = outputs active and counters running; 0 = outputs blanked and counters held.
REQ-006 Port mode, input, 1 bit: 0 = DIRECT decode of a; 1 = SCAN through all outputs.
REQ-007 Port a, input, N bits: the DIRECT select, and the SCAN start index.
REQ-008 Port dwell, input, DWELL_W bits: a SCAN step lasts dwell+1 enabled cycles.
REQ-009 Port y, output, 2**N bits: registered one-hot output.
REQ-010 Port idx, output, N bits: the currently decoded index.
REQ-011 Port wrap, output, 1 bit: one-cycle pulse when SCAN moves from index 2**N-1 to 0.

Function
REQ-012 The controller SHALL have three states: IDLE, DIRECT and SCAN.
REQ-013 IDLE -> DIRECT when enable=1 and mode=0; IDLE -> SCAN when enable=1 and mode=1; any state -> IDLE when enable=0.
REQ-014 DIRECT <-> SCAN SHALL follow a change of mode at the next edge while enable=1.
REQ-015 In DIRECT, y = one-hot(a) and idx = a, both registered with 1-cycle latency; dwell is ignored and wrap = 0.
REQ-016 On entry to SCAN (from IDLE or DIRECT), idx SHALL load a, the dwell counter SHALL clear, and y = one-hot(a) at that same edge.
REQ-017 In SCAN, the dwell counter increments each cycle; when it equals the live dwell value it clears and idx increments modulo 2**N.
REQ-018 wrap = 1 for exactly the cycle in which idx becomes 0 by increment from 2**N-1, and 0 otherwise; loading a=0 on SCAN entry SHALL NOT assert wrap.
REQ-019 If dwell is lowered below the current count mid-step, the step SHALL end on the next cycle (count >= dwell advances), with no counter overflow.
REQ-020 dwell=0 SHALL advance idx every cycle.
REQ-021 In IDLE, y = 0 and wrap = 0; idx and the dwell counter hold their values.
REQ-022 The IDLE hold SHALL be transparent: y shows only one-hot(idx) or all-zero, never more than one bit set.
REQ-023 If enable and mode change in the same cycle, the enable rule (REQ-013) SHALL take precedence.
REQ-024 In SCAN, a change on a SHALL be ignored until SCAN is re-entered.

Reset
REQ-025 With rst=1 at a clock edge: state = IDLE, y = 0, idx = 0, wrap = 0, dwell counter = 0.
REQ-026 rst SHALL override enable and mode, including mid-scan; the first edge after release follows REQ-013.

Structure
REQ-027 A package scan_decoder_pkg SHALL hold the state encoding (IDLE=2'd0, DIRECT=2'd1, SCAN=2'd2) and the mode constants (MODE_DIRECT=0, MODE_SCAN=1).
REQ-028 A combinational sub-module onehot_dec (parameter N; ports sel and out) SHALL generate the one-hot value, and the top SHALL register its output.
REQ-029 The unused state encoding 2'd3 SHALL return to IDLE.

Verification (N=3, DWELL_W=4)
REQ-030 Reset, then enable=1, mode=0, sweep a=0..7 one per cycle -> each cycle y = 1<<a(prev), idx = a(prev), wrap never set.
REQ-031 mode=1, a=5, dwell=2, enable=1 -> y=00100000 for 3 cycles, then 01000000, then 10000000, then 00000001 with wrap=1 for one cycle.
REQ-032 SCAN with dwell=0 for 16 cycles -> idx advances every cycle and wrap pulses exactly twice, 8 cycles apart.
REQ-033 Mid-SCAN at idx=3, drop enable for 4 cycles, then raise it -> y=0 during the gap, then y=00001000 resuming with the dwell count held.
REQ-034 Mid-SCAN with dwell=9 and count=6, set dwell=2 -> idx advances on the next cycle.
REQ-035 Assert rst mid-SCAN at idx=6 -> next cycle y=0, idx=0, wrap=0; after release with enable=1, mode=0, a=2 -> y=00000100 one cycle later.

Source files
------------

// File: rtl/scan_decoder_nbit_pkg.sv
// Shared encodings for the scan decoder: controller states and mode values.
package scan_decoder_pkg;

  // Controller state encoding; 2'd3 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // True for the three legal controller encodings.
  function automatic logic state_is_legal(input logic [1:0] st);
    logic ok;
    case (st)
      2'd0, 2'd1, 2'd2: ok = 1'b1;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/scan_decoder_nbit_onehot_dec.sv
// Combinational N-to-2**N one-hot decoder.
module onehot_dec
  import scan_decoder_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]    sel,
  output logic [2**N-1:0] out
);

  // Drive exactly one bit high at the selected position.
  always_comb begin
    out      = {(2**N){1'b0}};
    out[sel] = 1'b1;
  end

endmodule

// File: rtl/scan_decoder_nbit.sv
// Decoder that either follows a directly or steps through every output,
// holding each for dwell+1 enabled cycles. Outputs are registered.
module scan_decoder_nbit
  import scan_decoder_pkg::*;
#(
  parameter int N       = 3,
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               mode,
  input  logic [N-1:0]       a,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2**N-1:0]    y,
  output logic [N-1:0]       idx,
  output logic               wrap
);

  localparam logic [N-1:0]       IDX_ONE = N'(1'b1);
  localparam logic [N-1:0]       IDX_MAX = {N{1'b1}};
  localparam logic [DWELL_W-1:0] CNT_ONE = DWELL_W'(1'b1);

  state_e             state_r;
  logic [N-1:0]       idx_r;
  logic [DWELL_W-1:0] cnt_r;
  logic [2**N-1:0]    y_r;
  logic               wrap_r;
  // Set while IDLE was reached by pausing a scan; re-enabling SCAN then
  // resumes at the held index and count instead of reloading a.
  logic               paused_r;

  logic               state_ok_s;
  logic               scan_load_s;
  logic               cnt_done_s;
  logic [N-1:0]       idx_nxt_s;
  logic [2**N-1:0]    dec_s;

  // Classify the current cycle: legal state, fresh scan entry, step end.
  always_comb begin
    state_ok_s  = state_is_legal(state_r);
    scan_load_s = (state_r != SCAN) && !paused_r;
    // >= so a dwell lowered below the running count ends the step at once.
    cnt_done_s  = (cnt_r >= dwell);
  end

  // Index that the next edge will register; it also feeds the decoder so y
  // always matches idx.
  always_comb begin
    if (!state_ok_s || !enable) begin
      idx_nxt_s = idx_r;
    end else if (mode == MODE_DIRECT) begin
      idx_nxt_s = a;
    end else if (scan_load_s) begin
      idx_nxt_s = a;
    end else if (cnt_done_s) begin
      idx_nxt_s = idx_r + IDX_ONE;
    end else begin
      idx_nxt_s = idx_r;
    end
  end

  onehot_dec #(.N(N)) u_dec (
    .sel (idx_nxt_s),
    .out (dec_s)
  );

  // Controller FSM with registered y/idx/wrap and dwell counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      idx_r    <= {N{1'b0}};
      cnt_r    <= {DWELL_W{1'b0}};
      y_r      <= {(2**N){1'b0}};
      wrap_r   <= 1'b0;
      paused_r <= 1'b0;
    end else if (!state_ok_s) begin
      state_r  <= IDLE;
      y_r      <= {(2**N){1'b0}};
      wrap_r   <= 1'b0;
      paused_r <= 1'b0;
    end else if (!enable) begin
      state_r  <= IDLE;
      y_r      <= {(2**N){1'b0}};
      wrap_r   <= 1'b0;
      paused_r <= paused_r | (state_r == SCAN);
    end else if (mode == MODE_DIRECT) begin
      state_r  <= DIRECT;
      idx_r    <= idx_nxt_s;
      y_r      <= dec_s;
      wrap_r   <= 1'b0;
      paused_r <= 1'b0;
    end else if (scan_load_s) begin
      state_r  <= SCAN;
      idx_r    <= idx_nxt_s;
      cnt_r    <= {DWELL_W{1'b0}};
      y_r      <= dec_s;
      wrap_r   <= 1'b0;
      paused_r <= 1'b0;
    end else begin
      state_r  <= SCAN;
      idx_r    <= idx_nxt_s;
      y_r      <= dec_s;
      paused_r <= 1'b0;
      if (cnt_done_s) begin
        cnt_r  <= {DWELL_W{1'b0}};
        wrap_r <= (idx_r == IDX_MAX);
      end else begin
        cnt_r  <= cnt_r + CNT_ONE;
        wrap_r <= 1'b0;
      end
    end
  end

  assign y    = y_r;
  assign idx  = idx_r;
  assign wrap = wrap_r;

endmodule

// File: tb/tb_scan_decoder_nbit.sv
// Self-checking bench for scan_decoder_nbit (N=3, DWELL_W=4) using a
// behavioural model that queues expected outputs per driven cycle.
module tb_scan_decoder_nbit;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       mode;
  logic [2:0] a;
  logic [3:0] dwell;
  logic [7:0] y;
  logic [2:0] idx;
  logic       wrap;

  typedef struct packed {
    logic [7:0] y;
    logic [2:0] idx;
    logic       wrap;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  // Reference model state: 0 idle, 1 direct, 2 scan.
  int         m_st     = 0;
  logic [2:0] m_idx    = 3'd0;
  int         m_cnt    = 0;
  bit         m_paused = 1'b0;

  scan_decoder_nbit #(.N(3), .DWELL_W(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .mode   (mode),
    .a      (a),
    .dwell  (dwell),
    .y      (y),
    .idx    (idx),
    .wrap   (wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Advance the model by one edge using the currently driven inputs.
  task automatic model_push();
    exp_t x;
    x.wrap = 1'b0;
    if (rst) begin
      m_st = 0; m_idx = 3'd0; m_cnt = 0; m_paused = 1'b0;
      x.y = 8'd0;
    end else if (!enable) begin
      if (m_st == 2) m_paused = 1'b1;
      m_st = 0;
      x.y = 8'd0;
    end else if (mode == 1'b0) begin
      m_st = 1; m_idx = a; m_paused = 1'b0;
      x.y = 8'd1 << m_idx;
    end else if (m_st != 2 && !m_paused) begin
      m_st = 2; m_idx = a; m_cnt = 0;
      x.y = 8'd1 << m_idx;
    end else begin
      m_st = 2; m_paused = 1'b0;
      if (m_cnt >= int'(dwell)) begin
        m_cnt  = 0;
        x.wrap = (m_idx == 3'd7);
        m_idx  = m_idx + 3'd1;
      end else begin
        m_cnt = m_cnt + 1;
      end
      x.y = 8'd1 << m_idx;
    end
    x.idx = m_idx;
    sb_q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; mode = 1'b1; a = 3'd5; dwell = 4'd1;
    for (int i = 0; i < 2; i++) begin
      model_push();
      tick();
      e = sb_q.pop_front();
      total_cnt++;
      if (y !== e.y || idx !== e.idx || wrap !== e.wrap)
        $display("FAIL reset[%0d]: got y=%b idx=%0d wrap=%b, want y=%b idx=%0d wrap=%b", i, y, idx, wrap, e.y, e.idx, e.wrap);
      else pass_cnt++;
    end
    total_cnt++;
    if (y !== 8'd0 || idx !== 3'd0 || wrap !== 1'b0)
      $display("FAIL reset_const: got y=%b idx=%0d wrap=%b, want 0/0/0", y, idx, wrap);
    else pass_cnt++;
  endtask

  task automatic test_direct_sweep();
    rst = 1'b0; enable = 1'b1; mode = 1'b0; dwell = 4'd3;
    for (int i = 0; i < 8; i++) begin
      a = 3'(i);
      model_push();
      tick();
      e = sb_q.pop_front();
      total_cnt++;
      if (y !== e.y || idx !== e.idx || wrap !== e.wrap || y !== (8'd1 << i))
        $display("FAIL direct_sweep[%0d]: got y=%b idx=%0d wrap=%b, want y=%b idx=%0d wrap=%b", i, y, idx, wrap, e.y, e.idx, e.wrap);
      else pass_cnt++;
    end
  endtask

  task automatic test_scan_dwell2();
    logic [7:0] want_y;
    mode = 1'b1; a = 3'd5; dwell = 4'd2;
    for (int i = 0; i < 12; i++) begin
      model_push();
      tick();
      e = sb_q.pop_front();
      total_cnt++;
      if (y !== e.y || idx !== e.idx || wrap !== e.wrap)
        $display("FAIL scan_dwell2[%0d]: got y=%b idx=%0d wrap=%b, want y=%b idx=%0d wrap=%b", i, y, idx, wrap, e.y, e.idx, e.wrap);
      else pass_cnt++;
      if (i < 10) begin
        want_y = (i < 3) ? 8'b0010_0000 : (i < 6) ? 8'b0100_0000 :
                 (i < 9) ? 8'b1000_0000 : 8'b0000_0001;
        total_cnt++;
        if (y !== want_y || wrap !== (i == 9))
          $display("FAIL scan_dwell2_seq[%0d]: got y=%b wrap=%b, want y=%b wrap=%b", i, y, wrap, want_y, (i == 9));
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_dwell0();
    int n_wrap = 0;
    int first = -1;
    int second = -1;
    dwell = 4'd0;
    for (int i = 0; i < 16; i++) begin
      model_push();
      tick();
      e = sb_q.pop_front();
      total_cnt++;
      if (y !== e.y || idx !== e.idx || wrap !== e.wrap)
        $display("FAIL dwell0[%0d]: got y=%b idx=%0d wrap=%b, want y=%b idx=%0d wrap=%b", i, y, idx, wrap, e.y, e.idx, e.wrap);
      else pass_cnt++;
      if (wrap === 1'b1) begin
        n_wrap++;
        if (first < 0) first = i; else second = i;
      end
    end
    total_cnt++;
    if (n_wrap != 2 || (second - first) != 8)
      $display("FAIL dwell0_wraps: got %0d pulses spacing %0d, want 2 pulses spacing 8", n_wrap, second - first);
    else pass_cnt++;
  endtask

  task automatic test_pause();
    // Load idx=3 via DIRECT, then enter SCAN at 3 and spend one step cycle.
    mode = 1'b0; a = 3'd3; dwell = 4'd3;
    for (int i = 0; i < 10; i++) begin
      if (i == 1) mode = 1'b1;
      enable = !(i >= 3 && i < 7);
      model_push();
      tick();
      e = sb_q.pop_front();
      total_cnt++;
      if (y !== e.y || idx !== e.idx || wrap !== e.wrap)
        $display("FAIL pause[%0d]: got y=%b idx=%0d wrap=%b, want y=%b idx=%0d wrap=%b", i, y, idx, wrap, e.y, e.idx, e.wrap);
      else pass_cnt++;
      if (i >= 3 && i < 7) begin
        total_cnt++;
        if (y !== 8'd0 || idx !== 3'd3 || wrap !== 1'b0)
          $display("FAIL pause_gap[%0d]: got y=%b idx=%0d, want y=0 idx=3", i, y, idx);
        else pass_cnt++;
      end
      if (i == 7 || i == 8) begin
        total_cnt++;
        if (y !== 8'b0000_1000)
          $display("FAIL pause_resume[%0d]: got y=%b, want y=00001000", i, y);
        else pass_cnt++;
      end
      if (i == 9) begin
        total_cnt++;
        if (y !== 8'b0001_0000)
          $display("FAIL pause_count_held: got y=%b, want y=00010000", y);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_dwell_lower();
    enable = 1'b1; mode = 1'b0; a = 3'd1; dwell = 4'd9;
    for (int i = 0; i < 9; i++) begin
      if (i == 1) mode = 1'b1;
      if (i == 8) dwell = 4'd2;
      model_push();
      tick();
      e = sb_q.pop_front();
      total_cnt++;
      if (y !== e.y || idx !== e.idx || wrap !== e.wrap)
        $display("FAIL dwell_lower[%0d]: got y=%b idx=%0d wrap=%b, want y=%b idx=%0d wrap=%b", i, y, idx, wrap, e.y, e.idx, e.wrap);
      else pass_cnt++;
    end
    total_cnt++;
    if (idx !== 3'd2)
      $display("FAIL dwell_lower_adv: got idx=%0d, want 2", idx);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_scan();
    enable = 1'b1; mode = 1'b0; a = 3'd6; dwell = 4'd5;
    for (int i = 0; i < 5; i++) begin
      rst  = (i == 3);
      mode = (i == 1 || i == 2 || i == 3);
      if (i == 4) a = 3'd2;
      model_push();
      tick();
      e = sb_q.pop_front();
      total_cnt++;
      if (y !== e.y || idx !== e.idx || wrap !== e.wrap)
        $display("FAIL rst_mid[%0d]: got y=%b idx=%0d wrap=%b, want y=%b idx=%0d wrap=%b", i, y, idx, wrap, e.y, e.idx, e.wrap);
      else pass_cnt++;
      if (i == 2) begin
        total_cnt++;
        if (idx !== 3'd6) $display("FAIL rst_mid_pre: got idx=%0d, want 6", idx);
        else pass_cnt++;
      end
      if (i == 3) begin
        total_cnt++;
        if (y !== 8'd0 || idx !== 3'd0 || wrap !== 1'b0)
          $display("FAIL rst_mid_clear: got y=%b idx=%0d wrap=%b, want 0/0/0", y, idx, wrap);
        else pass_cnt++;
      end
      if (i == 4) begin
        total_cnt++;
        if (y !== 8'b0000_0100)
          $display("FAIL rst_mid_release: got y=%b, want 00000100", y);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      rst    = ($urandom_range(0, 29) == 0);
      enable = ($urandom_range(0, 3) != 0);
      mode   = 1'($urandom_range(0, 1));
      a      = 3'($urandom_range(0, 7));
      dwell  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
      model_push();
      tick();
      e = sb_q.pop_front();
      total_cnt++;
      if (y !== e.y || idx !== e.idx || wrap !== e.wrap)
        $display("FAIL back_to_back[%0d]: got y=%b idx=%0d wrap=%b, want y=%b idx=%0d wrap=%b", i, y, idx, wrap, e.y, e.idx, e.wrap);
      else pass_cnt++;
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; mode = 1'b0; a = 3'd0; dwell = 4'd0;
    #2;
    test_reset();
    test_direct_sweep();
    test_scan_dwell2();
    test_dwell0();
    test_pause();
    test_dwell_lower();
    test_reset_mid_scan();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
